// File: rtl/cc_micro_sequencer_if.sv
// Bus bundle between the micro-sequencer and the rest of the control unit.
// The signal names match the sequencer's external pin list.
interface cc_micro_sequencer_if #(
  parameter int DATAWIDTH_BUS           = 11,
  parameter int DATAWIDTH_MUX_SELECTION = 2,
  parameter int DATAWIDTH_COND          = 3
);
  logic [DATAWIDTH_COND-1:0]          CC_SEQ_Cond_InBUS;
  logic [3:0]                         CC_SEQ_Flags_InBUS;
  logic                               CC_SEQ_IR13_In;
  logic                               CC_SEQ_MemReq_In;
  logic                               CC_SEQ_MemDone_In;
  logic                               CC_SEQ_Halt_In;
  logic [DATAWIDTH_BUS-1:0]           CC_SEQ_NextAddr_InBUS;
  logic [DATAWIDTH_BUS-1:0]           CC_SEQ_Address_OutBUS;
  logic [DATAWIDTH_BUS-1:0]           CC_SEQ_Next_OutBUS;
  logic [DATAWIDTH_MUX_SELECTION-1:0] CC_SEQ_Selection_OutBUS;
  logic                               CC_SEQ_Stall_Out;
  logic                               CC_SEQ_Timeout_Out;
  logic [1:0]                         CC_SEQ_State_OutBUS;

  // Control unit side: drives microword fields, flags and mux result.
  modport master (
    output CC_SEQ_Cond_InBUS, CC_SEQ_Flags_InBUS, CC_SEQ_IR13_In, CC_SEQ_MemReq_In,
           CC_SEQ_MemDone_In, CC_SEQ_Halt_In, CC_SEQ_NextAddr_InBUS,
    input  CC_SEQ_Address_OutBUS, CC_SEQ_Next_OutBUS, CC_SEQ_Selection_OutBUS,
           CC_SEQ_Stall_Out, CC_SEQ_Timeout_Out, CC_SEQ_State_OutBUS
  );

  // Sequencer side.
  modport slave (
    input  CC_SEQ_Cond_InBUS, CC_SEQ_Flags_InBUS, CC_SEQ_IR13_In, CC_SEQ_MemReq_In,
           CC_SEQ_MemDone_In, CC_SEQ_Halt_In, CC_SEQ_NextAddr_InBUS,
    output CC_SEQ_Address_OutBUS, CC_SEQ_Next_OutBUS, CC_SEQ_Selection_OutBUS,
           CC_SEQ_Stall_Out, CC_SEQ_Timeout_Out, CC_SEQ_State_OutBUS
  );
endinterface

// File: rtl/cc_micro_sequencer.sv
// Control-store address register with branch-condition decode, memory-wait
// stalling and a sticky memory-timeout halt.
module cc_micro_sequencer #(
  parameter int                         DATAWIDTH_BUS           = 11,
  parameter int                         DATAWIDTH_MUX_SELECTION = 2,
  parameter int                         DATAWIDTH_COND          = 3,
  parameter logic [DATAWIDTH_BUS-1:0]   RESET_ADDR              = '0,
  parameter int                         DATAWIDTH_TIMEOUT       = 8,
  parameter int                         TIMEOUT_CYCLES          = 200
) (
  input  logic                 CC_SEQ_CLOCK_50,
  input  logic                 CC_SEQ_RESET_InLow,
  cc_micro_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    WAIT = 2'b01,
    HALT = 2'b10
  } state_t;

  localparam logic [DATAWIDTH_TIMEOUT-1:0] CNT_LAST = DATAWIDTH_TIMEOUT'(TIMEOUT_CYCLES - 1);
  localparam logic [DATAWIDTH_MUX_SELECTION-1:0] SEL_NEXT   = DATAWIDTH_MUX_SELECTION'(0);
  localparam logic [DATAWIDTH_MUX_SELECTION-1:0] SEL_JUMP   = DATAWIDTH_MUX_SELECTION'(1);
  localparam logic [DATAWIDTH_MUX_SELECTION-1:0] SEL_DECODE = DATAWIDTH_MUX_SELECTION'(2);

  state_t                         state, state_nx;
  logic [DATAWIDTH_BUS-1:0]       addr, addr_nx;
  logic [DATAWIDTH_TIMEOUT-1:0]   cnt, cnt_nx;
  logic                           timeout, timeout_nx;
  logic                           stall;
  logic [DATAWIDTH_MUX_SELECTION-1:0] sel;

  logic flag_n, flag_z, flag_v, flag_c;
  assign {flag_n, flag_z, flag_v, flag_c} = bus.CC_SEQ_Flags_InBUS;

  // Branch-condition decode: a pure function of the current microword and flags.
  always_comb begin
    sel = SEL_NEXT;
    case (bus.CC_SEQ_Cond_InBUS)
      DATAWIDTH_COND'(1): sel = flag_n            ? SEL_JUMP : SEL_NEXT;
      DATAWIDTH_COND'(2): sel = flag_z            ? SEL_JUMP : SEL_NEXT;
      DATAWIDTH_COND'(3): sel = flag_v            ? SEL_JUMP : SEL_NEXT;
      DATAWIDTH_COND'(4): sel = flag_c            ? SEL_JUMP : SEL_NEXT;
      DATAWIDTH_COND'(5): sel = bus.CC_SEQ_IR13_In ? SEL_JUMP : SEL_NEXT;
      DATAWIDTH_COND'(6): sel = SEL_JUMP;
      DATAWIDTH_COND'(7): sel = SEL_DECODE;
      default:            sel = SEL_NEXT;
    endcase
  end

  // Next-state logic: load the mux result unless stalled on memory or halted.
  always_comb begin
    state_nx   = state;
    addr_nx    = addr;
    cnt_nx     = cnt;
    timeout_nx = timeout;
    stall      = 1'b0;
    case (state)
      RUN: begin
        // Halt wins over a memory request issued in the same microword.
        if (bus.CC_SEQ_Halt_In) begin
          state_nx = HALT;
          stall    = 1'b1;
        end else if (bus.CC_SEQ_MemReq_In && !bus.CC_SEQ_MemDone_In) begin
          state_nx = WAIT;
          cnt_nx   = '0;
          stall    = 1'b1;
        end else begin
          addr_nx  = bus.CC_SEQ_NextAddr_InBUS;
        end
      end
      WAIT: begin
        // Halt requests are ignored here so the access can finish or time out.
        if (bus.CC_SEQ_MemDone_In) begin
          addr_nx  = bus.CC_SEQ_NextAddr_InBUS;
          state_nx = RUN;
        end else begin
          stall = 1'b1;
          if (cnt == CNT_LAST) begin
            timeout_nx = 1'b1;
            state_nx   = HALT;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      HALT: stall = 1'b1;
      default: state_nx = RUN;  // illegal encoding: recover, hold address
    endcase
  end

  // State, address, wait counter and fault flag registers.
  always_ff @(posedge CC_SEQ_CLOCK_50 or negedge CC_SEQ_RESET_InLow) begin
    if (!CC_SEQ_RESET_InLow) begin
      state   <= RUN;
      addr    <= RESET_ADDR;
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nx;
      addr    <= addr_nx;
      cnt     <= cnt_nx;
      timeout <= timeout_nx;
    end
  end

  assign bus.CC_SEQ_Address_OutBUS   = addr;
  assign bus.CC_SEQ_Next_OutBUS      = addr + 1'b1;
  assign bus.CC_SEQ_Selection_OutBUS = sel;
  assign bus.CC_SEQ_Stall_Out        = stall;
  assign bus.CC_SEQ_Timeout_Out      = timeout;
  assign bus.CC_SEQ_State_OutBUS     = state;

endmodule
